// File: rtl/spike_event_arbiter.sv
// spike_event_arbiter
//   Round-robin merge of NUM_REQ neuron-side valid/ready event sources into a
//   single registered output stage. Each event is tagged with its source index.
//   Pop and push can happen in the same cycle, so sustained throughput is one
//   event per cycle.
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   arb_en      : 1 = new grants allowed; 0 = output stage still drains
//   req_valid   : per-requester event present
//   req_data    : per-requester payload, requester i at [i*DATA_W +: DATA_W]
//   req_ready   : one-hot (or zero) grant, combinational
//   out_valid   : output stage holds an event
//   out_data    : held payload
//   out_id      : source index of held payload
//   out_ready   : downstream accept
//   busy        : out_valid or any request pending
module spike_event_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      arb_en,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [ID_W-1:0]           out_id,
  input  logic                      out_ready,
  output logic                      busy
);

  logic              full;
  logic [DATA_W-1:0] data_q;
  logic [ID_W-1:0]   id_q;
  logic [ID_W-1:0]   rr_ptr;

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [ID_W-1:0]      offset;
  logic                 hit;
  logic [ID_W:0]        idx_sum;
  logic [ID_W-1:0]      winner;
  logic [ID_W:0]        ptr_inc;
  logic [ID_W-1:0]      rr_next;
  logic [DATA_W-1:0]    win_data;
  logic                 can_accept;
  logic                 push;

  // Rotate the request vector so rr_ptr lands on bit 0; the first set bit of
  // the rotated vector is then the round-robin winner's distance from rr_ptr.
  assign req_dbl = {req_valid, req_valid};
  assign req_rot = NUM_REQ'(req_dbl >> rr_ptr);

  always_comb begin
    offset = '0;
    hit    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!hit && req_rot[k]) begin
        hit    = 1'b1;
        offset = ID_W'(k);
      end
    end
  end

  // Modulo-NUM_REQ add; handles NUM_REQ that is not a power of two.
  assign idx_sum = {1'b0, rr_ptr} + {1'b0, offset};
  assign winner  = (idx_sum >= (ID_W+1)'(NUM_REQ)) ?
                   ID_W'(idx_sum - (ID_W+1)'(NUM_REQ)) : idx_sum[ID_W-1:0];

  assign ptr_inc = {1'b0, winner} + (ID_W+1)'(1);
  assign rr_next = (ptr_inc == (ID_W+1)'(NUM_REQ)) ? '0 : ptr_inc[ID_W-1:0];

  // Constant-index mux keeps req_data out of every combinational output path.
  always_comb begin
    win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (winner == ID_W'(k)) win_data = req_data[k*DATA_W +: DATA_W];
    end
  end

  assign can_accept = arb_en & (~full | out_ready);
  // rst_n gates the grant so no requester sees a handshake while in reset.
  assign push       = can_accept & hit & rst_n;

  always_comb begin
    req_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (push && (winner == ID_W'(k))) req_ready[k] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full   <= 1'b0;
      data_q <= '0;
      id_q   <= '0;
      rr_ptr <= '0;
    end else begin
      if (push) begin
        full   <= 1'b1;
        data_q <= win_data;
        id_q   <= winner;
        rr_ptr <= rr_next;
      end else if (full && out_ready) begin
        full <= 1'b0;
      end
    end
  end

  assign out_valid = full;
  assign out_data  = data_q;
  assign out_id    = id_q;
  assign busy      = full | (|req_valid);

endmodule

// File: tb/tb_spike_event_arbiter.sv
module tb_spike_event_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic          clk;
  logic          rst_n;
  logic          arb_en;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_id;
  logic          out_ready;
  logic          busy;

  spike_event_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
    .out_ready(out_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a pointer integer, a full flag and a queue of expected
  // output events (id in [15:8], data in [7:0]).
  int           m_rr   = 0;
  bit           m_full = 0;
  logic [15:0]  sb[$];
  logic [N-1:0] last_grant = '0;

  // Model / grant checker: runs 3 time units after each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        check("req_ready_in_reset", 32'(req_ready), 32'd0);
        m_rr = 0;
        m_full = 0;
        sb.delete();
        last_grant = '0;
      end else begin
        int w;
        logic [N-1:0] eg;
        w  = -1;
        eg = '0;
        if (arb_en && (!m_full || out_ready)) begin
          for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_rr + k) % N;
            if (w < 0 && req_valid[idx]) w = idx;
          end
        end
        if (w >= 0) eg[w] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(eg));
        check("busy", 32'(busy), 32'(m_full || (req_valid != 0)));
        if (w >= 0) begin
          logic [7:0] wid;
          wid = 8'(w);
          sb.push_back({wid, req_data[w*DW +: DW]});
          m_rr   = (w + 1) % N;
          m_full = 1;
        end else if (m_full && out_ready) begin
          m_full = 0;
        end
        last_grant = eg;
      end
    end
  end

  // Monitor: runs 2 time units after each falling edge, before the model.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        check("out_valid", 32'(out_valid), 32'(m_full));
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("pop_without_expected_event", 32'd1, 32'd0);
          end else begin
            logic [15:0] e;
            e = sb.pop_front();
            check("out_id", 32'(out_id), 32'(e[15:8]));
            check("out_data", 32'(out_data), 32'(e[7:0]));
          end
        end
      end
    end
  end

  // One stimulus cycle. Pending requests keep their data until granted;
  // pdrop is the chance (percent) that an ungranted request is withdrawn.
  task automatic rand_cycle(input int pv, input int pdrop, input int pe, input int pr);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && !last_grant[i]) begin
        if (int'($urandom_range(99)) < pdrop) req_valid[i] = 1'b0;
      end else begin
        req_valid[i] = (int'($urandom_range(99)) < pv);
        req_data[i*DW +: DW] = DW'($urandom);
      end
    end
    arb_en    = (int'($urandom_range(99)) < pe);
    out_ready = (int'($urandom_range(99)) < pr);
  endtask

  initial begin
    rst_n     = 1'b0;
    arb_en    = 1'b0;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_out_id", 32'(out_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester 2 with payload 0xA5.
    @(negedge clk);
    req_valid = 4'b0100;
    req_data[2*DW +: DW] = 8'hA5;
    arb_en    = 1'b1;
    out_ready = 1'b1;
    #1;
    check("single_req_ready", 32'(req_ready), 32'h4);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("single_out_data", 32'(out_data), 32'hA5);
    check("single_out_id", 32'(out_id), 32'd2);

    // All requesters continuously valid, full throughput.
    repeat (10) rand_cycle(100, 0, 100, 100);
    // Backpressure with all valid.
    repeat (5) rand_cycle(100, 0, 100, 0);
    repeat (4) rand_cycle(100, 0, 100, 100);
    // arb_en low while full: held event drains, no grants.
    repeat (4) rand_cycle(100, 0, 0, 100);
    repeat (4) rand_cycle(100, 0, 100, 100);

    // Mixed random traffic.
    repeat (400) rand_cycle(40, 10, 85, 70);
    repeat (200) rand_cycle(15, 5, 95, 90);

    // Reset while out_valid=1.
    @(negedge clk);
    req_valid = '1;
    arb_en    = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    #1;
    check("pre_reset_out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", 32'(out_valid), 32'd0);
    check("async_reset_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    req_valid = 4'b1010;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("post_reset_first_grant", 32'(req_ready), 32'h2);

    repeat (300) rand_cycle(60, 10, 90, 60);

    // Drain with arbitration disabled.
    @(negedge clk);
    arb_en    = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #4;
    check("drain_scoreboard_empty", 32'(sb.size()), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
